safe_lockstep_mux: RTL

//  Configurable interconnect stage between the NHARTS cores of the external CPU system and the bus.

---
 rtl/safe_lockstep_mux_pkg.sv | 22 ++
 rtl/safe_lockstep_mux.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/safe_lockstep_mux_pkg.sv
// OBI request/response payloads shared by the lockstep interconnect stage.
package safe_lockstep_mux_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef struct packed {
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/safe_lockstep_mux.sv
// Interconnect stage between NHARTS cores and the bus: independent pass-through
// or lockstep (one master drives the bus, shadows are compared against it).
module safe_lockstep_mux
  import safe_lockstep_mux_pkg::*;
#(
  parameter int unsigned NHARTS    = 2,
  parameter int unsigned MASTER_ID = 0,
  parameter int unsigned OUTST_W   = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  obi_req_t  [NHARTS-1:0]  core_instr_req_i,
  output obi_resp_t [NHARTS-1:0]  core_instr_resp_o,
  input  obi_req_t  [NHARTS-1:0]  core_data_req_i,
  output obi_resp_t [NHARTS-1:0]  core_data_resp_o,
  output obi_req_t  [NHARTS-1:0]  bus_instr_req_o,
  input  obi_resp_t [NHARTS-1:0]  bus_instr_resp_i,
  output obi_req_t  [NHARTS-1:0]  bus_data_req_o,
  input  obi_resp_t [NHARTS-1:0]  bus_data_resp_i,
  input  logic                    lockstep_req_i,
  output logic                    mode_o,
  output logic                    switch_done_o,
  output logic                    mismatch_o,
  output logic                    error_o,
  output logic [CNT_W-1:0]        mismatch_cnt_o,
  input  logic                    clear_i
);

  localparam int unsigned NCH     = 2;
  localparam int unsigned CH_DATA = 1;
  localparam int unsigned MID     = MASTER_ID;
  localparam logic [OUTST_W-1:0] OUTST_MAX = '1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_INDEP,
    ST_DRAIN_LS,
    ST_LOCKSTEP,
    ST_DRAIN_IN
  } state_e;

  state_e state_q, state_d;
  logic   mode_q, mode_d;
  logic   switch_done_q, switch_done_d;
  logic   mismatch_q, mismatch_c;
  logic   error_q, error_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][NHARTS-1:0][OUTST_W-1:0] outst_q, outst_d;

  obi_req_t  [NCH-1:0][NHARTS-1:0] core_req, bus_req;
  obi_resp_t [NCH-1:0][NHARTS-1:0] bus_resp, core_resp;
  logic      [NCH-1:0][NHARTS-1:0] outst_full, inc, dec;
  logic all_idle;
  logic draining;

  // Channel 0 = instr, channel 1 = data
  assign core_req[0]       = core_instr_req_i;
  assign core_req[1]       = core_data_req_i;
  assign bus_resp[0]       = bus_instr_resp_i;
  assign bus_resp[1]       = bus_data_resp_i;
  assign bus_instr_req_o   = bus_req[0];
  assign bus_data_req_o    = bus_req[1];
  assign core_instr_resp_o = core_resp[0];
  assign core_data_resp_o  = core_resp[1];

  assign draining = (state_q == ST_DRAIN_LS) || (state_q == ST_DRAIN_IN);

  // Outstanding-counter status: per-port full flags and global idle
  always_comb begin
    all_idle   = 1'b1;
    outst_full = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      for (int unsigned h = 0; h < NHARTS; h++) begin
        outst_full[c][h] = (outst_q[c][h] == OUTST_MAX);
        if (outst_q[c][h] != '0) all_idle = 1'b0;
      end
    end
  end

  // Request/response routing; mode_q still reflects the previous mode while draining
  always_comb begin
    bus_req   = '0;
    core_resp = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      for (int unsigned h = 0; h < NHARTS; h++) begin
        if (mode_q) begin
          core_resp[c][h] = bus_resp[c][MID];
          if (draining || outst_full[c][MID]) core_resp[c][h].gnt = 1'b0;
        end else begin
          core_resp[c][h] = bus_resp[c][h];
          if (draining || outst_full[c][h]) core_resp[c][h].gnt = 1'b0;
        end
        if (!draining && (!mode_q || (h == MID))) begin
          bus_req[c][h] = core_req[c][h];
          if (outst_full[c][h]) bus_req[c][h].req = 1'b0;
        end
      end
    end
    if (!rst_ni) begin
      bus_req   = '0;
      core_resp = '0;
    end
  end

  // Outstanding counters: +1 on accepted request, -1 on response, stray responses ignored
  always_comb begin
    outst_d = outst_q;
    inc     = '0;
    dec     = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      for (int unsigned h = 0; h < NHARTS; h++) begin
        inc[c][h] = bus_req[c][h].req && bus_resp[c][h].gnt;
        dec[c][h] = bus_resp[c][h].rvalid && (outst_q[c][h] != '0);
        if (inc[c][h] && !dec[c][h]) begin
          outst_d[c][h] = outst_q[c][h] + OUTST_W'(1);
        end else if (!inc[c][h] && dec[c][h]) begin
          outst_d[c][h] = outst_q[c][h] - OUTST_W'(1);
        end
      end
    end
  end

  function automatic logic req_differs(obi_req_t m, obi_req_t s, logic is_data);
    logic d;
    d = (m.req != s.req);
    if (m.req && s.req) begin
      if (m.addr != s.addr) d = 1'b1;
      if (is_data && ((m.we != s.we) || (m.be != s.be))) d = 1'b1;
      if (is_data && m.we && s.we && (m.wdata != s.wdata)) d = 1'b1;
    end
    return d;
  endfunction

  // Shadow-vs-master comparison, active only in steady LOCKSTEP
  always_comb begin
    mismatch_c = 1'b0;
    if (state_q == ST_LOCKSTEP) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        for (int unsigned h = 0; h < NHARTS; h++) begin
          if ((h != MID) && req_differs(core_req[c][MID], core_req[c][h], (c == CH_DATA))) begin
            mismatch_c = 1'b1;
          end
        end
      end
    end
  end

  // Saturating mismatch counter and sticky error; clear wins over increment
  always_comb begin
    cnt_d   = cnt_q;
    error_d = error_q;
    if (clear_i) begin
      cnt_d   = '0;
      error_d = 1'b0;
    end else if (mismatch_c) begin
      error_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Mode FSM: drain all outstanding traffic before applying a mode change
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    switch_done_d = 1'b0;
    case (state_q)
      ST_INDEP:    if (lockstep_req_i) state_d = ST_DRAIN_LS;
      ST_DRAIN_LS: if (all_idle) begin
        state_d       = ST_LOCKSTEP;
        mode_d        = 1'b1;
        switch_done_d = 1'b1;
      end
      ST_LOCKSTEP: if (!lockstep_req_i) state_d = ST_DRAIN_IN;
      ST_DRAIN_IN: if (all_idle) begin
        state_d       = ST_INDEP;
        mode_d        = 1'b0;
        switch_done_d = 1'b1;
      end
      default:     state_d = ST_INDEP;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_INDEP;
      mode_q        <= 1'b0;
      switch_done_q <= 1'b0;
      mismatch_q    <= 1'b0;
      error_q       <= 1'b0;
      cnt_q         <= '0;
      outst_q       <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      switch_done_q <= switch_done_d;
      mismatch_q    <= mismatch_c;
      error_q       <= error_d;
      cnt_q         <= cnt_d;
      outst_q       <= outst_d;
    end
  end

  assign mode_o         = mode_q;
  assign switch_done_o  = switch_done_q;
  assign mismatch_o     = mismatch_q;
  assign error_o        = error_q;
  assign mismatch_cnt_o = cnt_q;

endmodule
